conv5x5_window_gen: RTL
=======================

Name: conv5x5_window_gen

Overview:
- Upstream feeder for the 5x5 convolution stage.
- Accepts a raster-order 8-bit pixel stream, one pixel per valid cycle.
- Buffers the last 4 image rows in line memories and emits the full 5x5 neighbourhood as a flat 25-element bus, one window per accepted pixel, for "valid" convolution positions only (no padding).
- Output bus maps element k directly onto the convolution stage's in_data_k inputs.

Parameters:
- DATA_W, 8, pixel width in bits
- IMG_W, 32, image width in pixels; minimum 5
- IMG_H, 32, image height in rows; minimum 5

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  pixel present this cycle
- in_sof  input  1  start of frame; only sampled when in_valid=1
- in_pixel  input  DATA_W  pixel value
- out_valid  output  1  out_win holds a new valid window
- out_last  output  1  window is the last one of the frame; only meaningful with out_valid
- out_win  output  25*DATA_W  window; element k = r*5+c at bits [DATA_W*k +: DATA_W]
- out_row  output  clog2(IMG_H)  image row of the window's bottom-right pixel
- out_col  output  clog2(IMG_W)  image column of the window's bottom-right pixel

Interface note: one clock (clk); reset is asynchronous and active-low (rst_n).

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_last=0, out_win=0, out_row=0, out_col=0; row/col counters=0. Line-memory contents are not reset.
- State advances only on cycles with in_valid=1. With in_valid=0, nothing shifts or counts, out_valid=0, and out_win/out_row/out_col hold.
- Counters track the accepted pixel's position.
  - col increments per pixel and wraps IMG_W-1 -> 0, incrementing row.
  - row wraps IMG_H-1 -> 0 at the last pixel of the frame, so back-to-back frames need no in_sof.
- in_sof with in_valid: that pixel is taken as (row 0, col 0), overriding counters; the current frame aborts mid-operation.
  - Stale line-memory data is harmless: windows are gated until row>=4 of the new frame.
- Line memories: 4 cascaded delays of IMG_W accepted pixels each.
  - Stage n output = pixel from n+1 rows above the current column.
  - Read-before-write at the same address; address = col.
- Window register: 5 rows x 5 columns shift register.
  - On each accepted pixel, every row shifts left by one column.
  - New column entering at c=4: r=4 gets in_pixel; r=3..0 get line-memory outputs 1..4 rows above.
  - Element (r=0,c=0) = pixel (row-4, col-4); (4,4) = current pixel.
- Latency: out_valid=1 on the cycle after accepting a pixel with row>=4 and col>=4; otherwise 0 that cycle.
  - out_row/out_col are registered with the window.
- out_last=1 together with out_valid when the window's bottom-right is (IMG_H-1, IMG_W-1).
- Window count: (IMG_W-4)*(IMG_H-4) per frame.
- Row straddle: windows at col<4 are suppressed, so data straddling a row boundary is never emitted.
- No backpressure: the downstream conv stage is fully pipelined and always accepts.

Decomposition:
- Package conv5x5_pkg:
  - K=5, KK=25
  - default DATA_W
  - function win_idx(r,c) = r*5+c
  - window slice width constant
- One sub-module: conv_line_delay, a circular buffer of IMG_W x DATA_W with enable, read-before-write and col as address; instantiated 4 times in cascade.

Test Plan:
- Common setup: IMG_W=8, IMG_H=6; pixel (r,c) = r*8+c; continuous in_valid from reset release.
- Full-frame count and first window: stream one frame -> exactly 8 out_valid pulses.
  - First pulse is one cycle after pixel 36: element0=0, element24=36, out_row=4, out_col=4.
- Last window: same frame -> final pulse has out_last=1, element0=11, element12=29, element24=47, out_row=5, out_col=7; out_last=0 on all other pulses.
- Input gaps: same frame with in_valid toggling 1-0-1-0 -> identical window sequence, out_valid never asserted on a cycle following in_valid=0.
- Mid-frame in_sof restart: assert in_sof at pixel (3,2) of the first frame, then restart with a full frame of value (r*8+c)+100 -> no window until new pixel (4,4); first window element0=100, element24=136.
- Async reset mid-frame: drop rst_n for a partial cycle at pixel 40 -> out_valid and out_win go 0 immediately; after release, a fresh frame reproduces the first scenario exactly.
- Back-to-back frames without in_sof: 2 frames -> 16 windows; the second frame's first window equals the first frame's.

Source files
------------

// File: rtl/conv5x5_pkg.sv
// Shared constants and helpers for the 5x5 convolution window path.
package conv5x5_pkg;

    localparam int unsigned K              = 5;
    localparam int unsigned KK             = K * K;
    localparam int unsigned DEFAULT_DATA_W = 8;
    // Width of the flat window bus at the default pixel width
    localparam int unsigned WIN_W          = KK * DEFAULT_DATA_W;

    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
        return r * K + c;
    endfunction

endpackage

// File: rtl/conv_line_delay.sv
// One image row of delay: circular buffer addressed by column, read-before-write.
module conv_line_delay #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Combinational read returns the value written one row earlier at this column
    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/conv5x5_window_gen.sv
// Raster pixel stream to 5x5 sliding window generator, valid positions only.
module conv5x5_window_gen
    import conv5x5_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic                        in_sof,
    input  logic [DATA_W-1:0]           in_pixel,
    output logic                        out_valid,
    output logic                        out_last,
    output logic [KK*DATA_W-1:0]        out_win,
    output logic [$clog2(IMG_H)-1:0]    out_row,
    output logic [$clog2(IMG_W)-1:0]    out_col
);

    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned CW = $clog2(IMG_W);

    logic [RW-1:0]     row_q, cur_row;
    logic [CW-1:0]     col_q, cur_col;
    logic              at_win_pos, frame_end;
    logic [DATA_W-1:0] tap [K-1];
    logic [DATA_W-1:0] win [K][K];

    // in_sof forces the accepted pixel to (0,0), overriding the counters
    always_comb begin
        cur_row = in_sof ? '0 : row_q;
        cur_col = in_sof ? '0 : col_q;
    end

    assign at_win_pos = (32'(cur_row) >= K - 1) && (32'(cur_col) >= K - 1);
    assign frame_end  = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (in_valid) begin
            if (cur_col == CW'(IMG_W - 1)) begin
                col_q <= '0;
                row_q <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col_q <= cur_col + 1'b1;
                row_q <= cur_row;
            end
        end
    end

    // tap[n] carries the pixel n+1 rows above the current column
    for (genvar n = 0; n < K - 1; n++) begin : g_line
        logic [DATA_W-1:0] din;
        if (n == 0) begin : g_first
            assign din = in_pixel;
        end else begin : g_next
            assign din = tap[n-1];
        end
        conv_line_delay #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W),
            .AW     (CW)
        ) u_line (
            .clk  (clk),
            .en   (in_valid),
            .addr (cur_col),
            .din  (din),
            .dout (tap[n])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < K; r++) begin
                for (int unsigned c = 0; c < K; c++) begin
                    win[r][c] <= '0;
                end
            end
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            out_valid <= in_valid && at_win_pos;
            out_last  <= in_valid && at_win_pos && frame_end;
            if (in_valid) begin
                for (int unsigned r = 0; r < K; r++) begin
                    for (int unsigned c = 0; c < K - 1; c++) begin
                        win[r][c] <= win[r][c+1];
                    end
                end
                for (int unsigned r = 0; r < K - 1; r++) begin
                    win[r][K-1] <= tap[K-2-r];
                end
                win[K-1][K-1] <= in_pixel;
                out_row       <= cur_row;
                out_col       <= cur_col;
            end
        end
    end

    always_comb begin
        out_win = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                out_win[DATA_W*win_idx(r, c) +: DATA_W] = win[r][c];
            end
        end
    end

endmodule
